// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// default geometry and a pointer-width helper.
package dm_port_arbiter_pkg;

    localparam int DM_N_CORES = 4;
    localparam int DM_ADDR_W  = 12;
    localparam int DM_DATA_W  = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Width of a core index; a single-core build still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first eligible core at or after ptr,
// wrapping from N_CORES-1 back to 0.
module rr_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int  N_CORES = DM_N_CORES,
    localparam int PTR_W   = ptr_width(N_CORES)
) (
    input  logic [N_CORES-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [N_CORES-1:0] winner,
    output logic               valid
);

    always_comb begin
        int               sum;
        logic [PTR_W-1:0] idx;
        winner = '0;
        valid  = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int off = 0; off < N_CORES; off++) begin
            sum = int'(ptr) + off;
            if (sum >= N_CORES) sum = sum - N_CORES;
            idx = PTR_W'(sum);
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one single-port data memory between N_CORES processor cores with
// registered round-robin grants and a one-cycle read-return strobe.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int  N_CORES = DM_N_CORES,
    parameter int  ADDR_W  = DM_ADDR_W,
    parameter int  DATA_W  = DM_DATA_W,
    localparam int PTR_W   = ptr_width(N_CORES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_process,
    input  logic [N_CORES-1:0]          req,
    input  logic [N_CORES-1:0]          we,
    input  logic [N_CORES*ADDR_W-1:0]   addr,
    input  logic [N_CORES*DATA_W-1:0]   wdata,
    input  logic [N_CORES-1:0]          core_done,
    input  logic [DATA_W-1:0]           dm_rdata,
    output logic                        dm_en,
    output logic [ADDR_W-1:0]           dm_addr,
    output logic [DATA_W-1:0]           dm_wdata,
    output logic [N_CORES-1:0]          gnt,
    output logic [N_CORES-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic                        end_process
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [PTR_W-1:0]   ptr;

    logic [N_CORES-1:0] eligible_p0;
    logic [N_CORES-1:0] winner_p0;
    logic               win_vld_p0;
    logic [PTR_W-1:0]   win_idx_p0;
    logic               win_we_p0;
    logic [ADDR_W-1:0]  win_addr_p0;
    logic [DATA_W-1:0]  win_wdata_p0;
    logic [PTR_W-1:0]   ptr_nxt_p0;

    // Stage 0: arbitration. The core granted this cycle sits out the next edge.
    assign eligible_p0 = (state == ST_RUN) ? (req & ~gnt) : '0;

    rr_arbiter #(
        .N_CORES (N_CORES)
    ) u_rr_arbiter (
        .eligible (eligible_p0),
        .ptr      (ptr),
        .winner   (winner_p0),
        .valid    (win_vld_p0)
    );

    always_comb begin
        win_idx_p0   = '0;
        win_we_p0    = 1'b0;
        win_addr_p0  = '0;
        win_wdata_p0 = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (winner_p0[i]) begin
                win_idx_p0   = PTR_W'(i);
                win_we_p0    = we[i];
                win_addr_p0  = addr[i*ADDR_W +: ADDR_W];
                win_wdata_p0 = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_nxt_p0 = (win_idx_p0 == PTR_W'(N_CORES - 1)) ? '0 : win_idx_p0 + PTR_W'(1);

    // Abort takes precedence over completion when both arrive together.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_process) state_nxt = ST_RUN;
            ST_RUN: begin
                if (!start_process)       state_nxt = ST_IDLE;
                else if (&core_done)      state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  if (!start_process) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Stage 1: grant register. A grant on the leaving-RUN edge still goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gnt      <= '0;
            dm_en    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            rvalid   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= winner_p0;
            // Stage 2: read return, one cycle behind a read grant in any state.
            rvalid <= dm_en ? '0 : gnt;
            if (win_vld_p0) begin
                dm_en    <= win_we_p0;
                dm_addr  <= win_addr_p0;
                dm_wdata <= win_wdata_p0;
                ptr      <= ptr_nxt_p0;
            end else begin
                dm_en <= 1'b0;
            end
        end
    end

    assign rdata       = dm_rdata;
    assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
    assign end_process = (state == ST_DONE);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed vector table, reset/abort sequences,
// randomized traffic against a reference model, and an 8-core wrap check.
module tb_dm_port_arbiter;

    localparam int NA = 4, AWA = 12, DWA = 12;
    localparam int NB = 8, AWB = 10, DWB = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              a_start;
    logic [NA-1:0]     a_req, a_we, a_done;
    logic [NA*AWA-1:0] a_addr;
    logic [NA*DWA-1:0] a_wdata;
    logic [DWA-1:0]    a_dm_rdata;
    logic              a_dm_en;
    logic [AWA-1:0]    a_dm_addr;
    logic [DWA-1:0]    a_dm_wdata, a_rdata;
    logic [NA-1:0]     a_gnt, a_rvalid;
    logic              a_busy, a_end;

    logic              b_start;
    logic [NB-1:0]     b_req, b_we, b_done;
    logic [NB*AWB-1:0] b_addr;
    logic [NB*DWB-1:0] b_wdata;
    logic [DWB-1:0]    b_dm_rdata;
    logic              b_dm_en;
    logic [AWB-1:0]    b_dm_addr;
    logic [DWB-1:0]    b_dm_wdata, b_rdata;
    logic [NB-1:0]     b_gnt, b_rvalid;
    logic              b_busy, b_end;

    dm_port_arbiter #(.N_CORES(NA), .ADDR_W(AWA), .DATA_W(DWA)) dut_a (
        .clk(clk), .rst(rst), .start_process(a_start), .req(a_req), .we(a_we),
        .addr(a_addr), .wdata(a_wdata), .core_done(a_done), .dm_rdata(a_dm_rdata),
        .dm_en(a_dm_en), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata), .gnt(a_gnt),
        .rvalid(a_rvalid), .rdata(a_rdata), .busy(a_busy), .end_process(a_end)
    );

    dm_port_arbiter #(.N_CORES(NB), .ADDR_W(AWB), .DATA_W(DWB)) dut_b (
        .clk(clk), .rst(rst), .start_process(b_start), .req(b_req), .we(b_we),
        .addr(b_addr), .wdata(b_wdata), .core_done(b_done), .dm_rdata(b_dm_rdata),
        .dm_en(b_dm_en), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata), .gnt(b_gnt),
        .rvalid(b_rvalid), .rdata(b_rdata), .busy(b_busy), .end_process(b_end)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase of the run, last granted core, this cycle's grant.
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
    int             m_st, m_last, m_cur, m_rv;
    bit             m_cur_we, m_en;
    logic [AWA-1:0] m_addr;
    logic [DWA-1:0] m_wdata;

    task automatic model_reset();
        m_st = M_IDLE; m_last = NA - 1; m_cur = -1; m_rv = -1;
        m_cur_we = 1'b0; m_en = 1'b0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic model_edge();
        int win = -1;
        int c;
        m_rv = (m_cur >= 0 && !m_cur_we) ? m_cur : -1;
        if (m_st == M_RUN) begin
            for (int j = 1; j <= NA; j++) begin
                c = (m_last + j) % NA;
                if (win < 0 && a_req[c] && c != m_cur) win = c;
            end
        end
        if (win >= 0) begin
            m_last   = win;
            m_cur_we = a_we[win];
            m_en     = a_we[win];
            m_addr   = a_addr[win*AWA +: AWA];
            m_wdata  = a_wdata[win*DWA +: DWA];
        end else begin
            m_en = 1'b0;
        end
        m_cur = win;
        case (m_st)
            M_IDLE:  if (a_start) m_st = M_RUN;
            M_RUN:   if (!a_start) m_st = M_IDLE; else if (a_done == 4'hF) m_st = M_DRAIN;
            M_DRAIN: m_st = M_DONE;
            default: if (!a_start) m_st = M_IDLE;
        endcase
    endtask

    task automatic model_check();
        chk("gnt",      64'(a_gnt),      (m_cur >= 0) ? (64'd1 << m_cur) : 64'd0);
        chk("dm_en",    64'(a_dm_en),    64'(m_en));
        chk("dm_addr",  64'(a_dm_addr),  64'(m_addr));
        chk("dm_wdata", 64'(a_dm_wdata), 64'(m_wdata));
        chk("rvalid",   64'(a_rvalid),   (m_rv >= 0) ? (64'd1 << m_rv) : 64'd0);
        chk("busy",     64'(a_busy),     64'(m_st == M_RUN || m_st == M_DRAIN));
        chk("end",      64'(a_end),      64'(m_st == M_DONE));
        if (m_rv >= 0) chk("rdata", 64'(a_rdata), 64'(a_dm_rdata));
    endtask

    task automatic step();
        a_dm_rdata = DWA'($urandom);
        model_edge();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         do_rst;
        bit         start;
        logic [3:0] req, we, done;
        logic [3:0] e_gnt;
        bit         e_en;
        logic [3:0] e_rv;
        bit         e_busy, e_end;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, logic [3:0] q, logic [3:0] w, logic [3:0] d,
                                logic [3:0] g, bit en, logic [3:0] rv, bit b, bit e);
        vec_t v;
        v.do_rst = r; v.start = s; v.req = q; v.we = w; v.done = d;
        v.e_gnt = g; v.e_en = en; v.e_rv = rv; v.e_busy = b; v.e_end = e;
        return v;
    endfunction

    vec_t tbl[24];

    task automatic b_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // start, req -> gnt/en/rvalid/busy/end after the next edge
        tbl[0]  = mk(0,1,4'b0001,4'b0000,4'b0000, 4'b0000,0,4'b0000,1,0);
        tbl[1]  = mk(0,1,4'b0001,4'b0000,4'b0000, 4'b0001,0,4'b0000,1,0);
        tbl[2]  = mk(0,1,4'b0000,4'b0000,4'b0000, 4'b0000,0,4'b0001,1,0);
        tbl[3]  = mk(0,1,4'b0000,4'b0000,4'b0000, 4'b0000,0,4'b0000,1,0);
        tbl[4]  = mk(1,1,4'b1111,4'b1111,4'b0000, 4'b0000,0,4'b0000,1,0);
        tbl[5]  = mk(0,1,4'b1111,4'b1111,4'b0000, 4'b0001,1,4'b0000,1,0);
        tbl[6]  = mk(0,1,4'b1111,4'b1111,4'b0000, 4'b0010,1,4'b0000,1,0);
        tbl[7]  = mk(0,1,4'b1111,4'b1111,4'b0000, 4'b0100,1,4'b0000,1,0);
        tbl[8]  = mk(0,1,4'b1111,4'b1111,4'b0000, 4'b1000,1,4'b0000,1,0);
        tbl[9]  = mk(0,1,4'b1111,4'b1111,4'b0000, 4'b0001,1,4'b0000,1,0);
        tbl[10] = mk(0,1,4'b0000,4'b0000,4'b0000, 4'b0000,0,4'b0000,1,0);
        tbl[11] = mk(0,1,4'b0100,4'b0000,4'b0000, 4'b0100,0,4'b0000,1,0);
        tbl[12] = mk(0,1,4'b0100,4'b0000,4'b0000, 4'b0000,0,4'b0100,1,0);
        tbl[13] = mk(0,1,4'b0100,4'b0000,4'b0000, 4'b0100,0,4'b0000,1,0);
        tbl[14] = mk(0,1,4'b0100,4'b0000,4'b0000, 4'b0000,0,4'b0100,1,0);
        tbl[15] = mk(0,1,4'b0000,4'b0000,4'b0000, 4'b0000,0,4'b0000,1,0);
        tbl[16] = mk(0,1,4'b0001,4'b0000,4'b1111, 4'b0001,0,4'b0000,1,0);
        tbl[17] = mk(0,1,4'b0001,4'b0000,4'b1111, 4'b0000,0,4'b0001,0,1);
        tbl[18] = mk(0,1,4'b1111,4'b0000,4'b1111, 4'b0000,0,4'b0000,0,1);
        tbl[19] = mk(0,0,4'b1111,4'b0000,4'b1111, 4'b0000,0,4'b0000,0,0);
        tbl[20] = mk(0,0,4'b1111,4'b0000,4'b0000, 4'b0000,0,4'b0000,0,0);
        tbl[21] = mk(0,1,4'b0010,4'b0000,4'b0000, 4'b0000,0,4'b0000,1,0);
        tbl[22] = mk(0,0,4'b0010,4'b0000,4'b0000, 4'b0010,0,4'b0000,0,0);
        tbl[23] = mk(0,0,4'b0010,4'b0000,4'b0000, 4'b0000,0,4'b0010,0,0);

        rst = 1'b1;
        a_start = 0; a_req = '0; a_we = '0; a_done = '0; a_dm_rdata = '0;
        a_addr  = {12'h043, 12'h032, 12'h021, 12'h010};
        a_wdata = {12'hA03, 12'hA02, 12'hA01, 12'hA00};
        b_start = 0; b_req = '0; b_we = '0; b_done = '0; b_dm_rdata = '0;
        for (int i = 0; i < NB; i++) begin
            b_addr[i*AWB +: AWB]  = AWB'(i * 37 + 5);
            b_wdata[i*DWB +: DWB] = DWB'(16'hBEE0 + i);
        end
        model_reset();
        #3;
        chk("reset_a", {a_gnt, a_rvalid, a_dm_en, a_dm_addr, a_dm_wdata, a_busy, a_end}, 64'd0);
        chk("reset_b", {b_gnt, b_rvalid, b_dm_en, b_dm_addr, b_dm_wdata, b_busy, b_end}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            if (tbl[i].do_rst) apply_reset();
            a_start = tbl[i].start; a_req = tbl[i].req; a_we = tbl[i].we; a_done = tbl[i].done;
            step();
            chk($sformatf("vec%0d", i), {a_gnt, a_dm_en, a_rvalid, a_busy, a_end},
                {tbl[i].e_gnt, tbl[i].e_en, tbl[i].e_rv, tbl[i].e_busy, tbl[i].e_end});
            if (i == 1) chk("vec1_addr", 64'(a_dm_addr), 64'h010);
            if (i == 2) chk("vec2_rdata", 64'(a_rdata), 64'(a_dm_rdata));
        end

        // Reset between edges while a read return is pending.
        apply_reset();
        a_start = 1; a_req = 4'b0001; a_we = 4'b0000; a_done = '0;
        step();
        step();
        chk("pend_gnt", 64'(a_gnt), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {a_gnt, a_rvalid, a_dm_en, a_dm_addr, a_dm_wdata, a_busy, a_end}, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        a_start = 0; a_req = '0;
        step();
        chk("no_rv_after_rst", 64'(a_rvalid), 64'd0);
        step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) apply_reset();
            a_start = ($urandom_range(15) != 0);
            a_req   = NA'($urandom);
            a_we    = NA'($urandom);
            a_done  = ($urandom_range(7) == 0) ? 4'hF : NA'($urandom);
            a_addr  = (NA*AWA)'({$urandom, $urandom});
            a_wdata = (NA*DWA)'({$urandom, $urandom});
            step();
        end
        a_start = 0; a_req = '0;

        // Eight-core geometry: wrap from core 7 to core 0.
        b_start = 1; b_req = '0; b_we = 8'h80;
        b_step();
        chk("b_busy", {b_busy, b_gnt}, {1'b1, 8'h00});
        b_req = 8'h80;
        b_step();
        chk("b_g7", {b_gnt, b_dm_en, b_dm_addr, b_dm_wdata}, {8'h80, 1'b1, 10'h108, 16'hBEE7});
        b_req = 8'h81;
        b_step();
        chk("b_g0", {b_gnt, b_dm_en, b_dm_addr, b_dm_wdata, b_rvalid}, {8'h01, 1'b0, 10'h005, 16'hBEE0, 8'h00});
        b_dm_rdata = 16'h5A5A;
        b_step();
        chk("b_g7b", {b_gnt, b_dm_en, b_rvalid, b_rdata}, {8'h80, 1'b1, 8'h01, 16'h5A5A});
        b_step();
        chk("b_wrap", {b_gnt, b_rvalid}, {8'h01, 8'h00});
        b_done = 8'hFF; b_req = '0;
        b_step();
        chk("b_drain", {b_busy, b_end, b_gnt, b_rvalid}, {1'b1, 1'b0, 8'h00, 8'h01});
        b_step();
        chk("b_done", {b_busy, b_end}, {1'b0, 1'b1});
        b_start = 0;
        b_step();
        chk("b_idle", {b_busy, b_end}, {1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

Interface
REQ-001 The block SHALL have parameter N_CORES, default 4, giving the number of processor cores sharing one data memory.
REQ-002 The block SHALL have parameter ADDR_W, default 12, giving the data-memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 12, giving the data-memory word width.
REQ-004 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: start_process  in  1  level; high enables arbitration.
REQ-007 Port: req  in  N_CORES  per-core access request.
REQ-008 Port: we  in  N_CORES  per-core write (1) / read (0) qualifier.
REQ-009 Port: addr  in  N_CORES*ADDR_W  per-core address; core i at bits [i*ADDR_W +: ADDR_W].
REQ-010 Port: wdata  in  N_CORES*DATA_W  per-core write data, packed like addr.
REQ-011 Port: core_done  in  N_CORES  per-core completion level.
REQ-012 Port: dm_rdata  in  DATA_W  memory read data, valid one cycle after dm_addr is presented.
REQ-013 Port: dm_en  out  1  memory write enable.
REQ-014 Port: dm_addr  out  ADDR_W; dm_wdata  out  DATA_W  memory address/write data.
REQ-015 Port: gnt  out  N_CORES  one-hot, one-cycle grant pulse.
REQ-016 Port: rvalid  out  N_CORES  one-hot read-return strobe; rdata  out  DATA_W  read data.
REQ-017 Port: busy  out  1; end_process  out  1  completion flag.

Function
REQ-018 Control SHALL be an FSM with states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE->RUN when start_process=1; no grants issue in IDLE, DRAIN or DONE.
REQ-020 RUN: at each edge, if any eligible req bit is set, exactly one core SHALL be granted; gnt, dm_en (=we of winner), dm_addr, dm_wdata SHALL be registered from that winner's inputs (1-cycle latency req->gnt).
REQ-021 With no grant, dm_en SHALL be 0; dm_addr/dm_wdata SHALL hold their last values.
REQ-022 Arbitration SHALL be round-robin: after granting core k, search order is k+1, k+2, ... mod N_CORES; pointer wraps from N_CORES-1 to 0.
REQ-023 A core whose gnt bit is high in the current cycle SHALL be ineligible at the next edge (a core holding req receives at most one grant per two cycles; different cores may be granted back-to-back).
REQ-024 For a read grant to core i, rvalid[i] SHALL be 1 exactly in the following cycle, with rdata = dm_rdata combinationally; rvalid SHALL be 0 otherwise.
REQ-025 RUN->DRAIN when core_done is all ones; a grant issued at that same edge SHALL still complete.
REQ-026 DRAIN->DONE after one cycle, so any outstanding read return is delivered.
REQ-027 DONE: end_process=1; DONE->IDLE when start_process=0.
REQ-028 RUN->IDLE when start_process=0 (abort); an outstanding rvalid SHALL still be delivered; pointer is retained.
REQ-029 busy SHALL be 1 in RUN and DRAIN, 0 otherwise.
REQ-030 req bits seen in IDLE/DRAIN/DONE SHALL be ignored, not queued.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, gnt=0, rvalid=0, dm_en=0, dm_addr=0, dm_wdata=0, end_process=0, busy=0, round-robin pointer so core 0 has highest priority.
REQ-032 Reset mid-transaction SHALL drop any pending read return without emitting rvalid.

Structure
REQ-033 FSM state encoding and parameter defaults SHALL reside in the shared processor package.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (parametrised by N_CORES; inputs eligible mask and pointer, outputs one-hot winner and valid).

Verification
REQ-035 Reset then start_process=1, req=4'b0001, we=0, addr0=12'h010 -> gnt=0001 next cycle, dm_addr=12'h010, dm_en=0; rvalid=0001 and rdata=dm_rdata one cycle later.
REQ-036 All four cores hold req, we=1 -> grants cycle 0001,0010,0100,1000,0001 on consecutive cycles; dm_en=1 each cycle with matching dm_wdata.
REQ-037 Only core 2 holds req continuously -> gnt[2] pulses every second cycle, never two consecutive cycles.
REQ-038 core_done=4'b1111 in RUN during a read grant -> rvalid still delivered, DRAIN one cycle, then end_process=1; start_process=0 -> IDLE, end_process=0.
REQ-039 rst asserted mid-cycle while a read is pending -> all outputs 0 immediately, no rvalid after release.
REQ-040 N_CORES=8, ADDR_W=10, DATA_W=16: core 7 then core 0 request -> round-robin wrap 7->0 observed, address/data slicing correct.
